// File: rtl/cdc_hs_rx_pkg.sv
// Shared types and limits for the toggle-handshake CDC receive path.
package cdc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hs_state_e;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/cdc_hs_rx_if.sv
// Handshake bundle: source-side toggle req/ack with data, plus the
// downstream valid/ready data channel. The receiver uses the slave view.
interface cdc_hs_rx_if #(
  parameter int unsigned DW = 8
);

  logic          src_req;
  logic [DW-1:0] src_data;
  logic          src_ack;
  logic [DW-1:0] do_data;
  logic          do_vld;
  logic          do_rdy;

  modport master (
    output src_req,
    output src_data,
    input  src_ack,
    input  do_data,
    input  do_vld,
    output do_rdy
  );

  modport slave (
    input  src_req,
    input  src_data,
    output src_ack,
    output do_data,
    output do_vld,
    input  do_rdy
  );

endinterface

// File: rtl/cdc_hs_rx_sync.sv
// N-flop single-bit synchroniser, asynchronous active-low reset to 0.
module cdc_sync_bit #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// Destination side of a 2-phase req/ack crossing. Only src_req is
// synchronised; src_data is captured when the synchronised toggle is seen,
// relying on the source holding it stable until the ack toggle returns.
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  cdc_hs_rx_if.slave       hs,
  output logic             busy,
  output logic             proto_err,
  output logic [CNT_W-1:0] xfer_cnt
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("cdc_hs_rx: SYNC_STAGES must be in 2..4");
  end

  hs_state_e     state;
  logic          req_s;
  logic          req_last;
  logic          new_req;
  logic          src_ack_q;
  logic [DW-1:0] do_data_q;
  logic          do_vld_q;

  cdc_sync_bit #(
    .N (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (hs.src_req),
    .q   (req_s)
  );

  assign new_req = req_s ^ req_last;

  // Handshake FSM: capture on new toggle, hold until downstream accepts,
  // then return the ack toggle and count the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_last  <= 1'b0;
      src_ack_q <= 1'b0;
      do_data_q <= '0;
      do_vld_q  <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (new_req) begin
            do_data_q <= hs.src_data;
            req_last  <= req_s;
            do_vld_q  <= 1'b1;
            busy      <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // req_last is left untouched so an early toggle is served next.
          if (new_req) begin
            proto_err <= 1'b1;
          end
          if (hs.do_rdy) begin
            do_vld_q  <= 1'b0;
            busy      <= 1'b0;
            src_ack_q <= ~src_ack_q;
            xfer_cnt  <= xfer_cnt + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hs.src_ack = src_ack_q;
  assign hs.do_data = do_data_q;
  assign hs.do_vld  = do_vld_q;

endmodule
